// File: rtl/fmul_seq_if.sv
// Handshake bundle for fmul_seq: operand request channel plus result/flag channel.
interface fmul_seq_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         flag_nv;
  logic         flag_of;
  logic         flag_uf;
  logic         flag_nx;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, s, flag_nv, flag_of, flag_uf, flag_nx
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, s, flag_nv, flag_of, flag_uf, flag_nx
  );
endinterface

// File: rtl/fmul_seq.sv
// Sequential floating-point multiplier: radix-2 shift-add mantissa product, one
// multiplier bit per cycle, round-to-nearest-even, special values and exception flags.
module fmul_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic      clk,
  input  logic      rst_n,
  fmul_seq_if.slave bus
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int M     = MAN_W + 1;
  localparam int P     = 2 * M;
  localparam int XW    = EXP_W + 2;
  localparam int CNT_W = $clog2(M);

  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(MAN_W);
  localparam logic signed [XW-1:0] BIAS     = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = {XW{1'b0}};
  localparam logic [EXP_W-1:0]     EXP_ONES = {EXP_W{1'b1}};
  localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  // Operand class vector: {zero, inf, nan, signalling nan}; exp==0 counts as zero.
  function automatic logic [3:0] classify(input logic [W-1:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    logic             ones;
    e    = x[W-2:MAN_W];
    f    = x[MAN_W-1:0];
    ones = (e == EXP_ONES);
    return {e == {EXP_W{1'b0}},
            ones && (f == {MAN_W{1'b0}}),
            ones && (f != {MAN_W{1'b0}}),
            ones && (f != {MAN_W{1'b0}}) && !f[MAN_W-1]};
  endfunction

  state_t                 state_r, state_s;
  logic [CNT_W-1:0]       cnt_r;
  logic                   sign_r;
  logic signed [XW-1:0]   exp_r;
  logic [P-1:0]           mcand_r;
  logic [M-1:0]           mplier_r;
  logic [P-1:0]           acc_r;
  logic                   spec_r;
  logic [W-1:0]           spc_res_r;
  logic                   spc_nv_r;
  logic                   in_ready_r, out_valid_r;
  logic [W-1:0]           s_r;
  logic                   nv_r, of_r, uf_r, nx_r;

  logic [3:0]             cls_a_s, cls_b_s;
  logic                   special_s, sign_in_s, accept_s;
  logic [W-1:0]           spc_res_s;
  logic                   spc_nv_s;
  logic [P-1:0]           pn_s;
  logic [M-1:0]           kept_s;
  logic                   guard_s, sticky_s, inc_s;
  logic [M:0]             rnd_s;
  logic signed [XW-1:0]   e_fin_s;
  logic [W-1:0]           res_s;
  logic                   res_nv_s, res_of_s, res_uf_s, res_nx_s;

  assign cls_a_s   = classify(bus.a);
  assign cls_b_s   = classify(bus.b);
  assign special_s = (|cls_a_s[3:1]) || (|cls_b_s[3:1]);
  assign sign_in_s = bus.a[W-1] ^ bus.b[W-1];
  assign accept_s  = bus.in_valid && in_ready_r;

  // Special-operand result, resolved at accept so those operations skip MUL.
  always_comb begin
    spc_res_s = {sign_in_s, {(W-1){1'b0}}};
    spc_nv_s  = 1'b0;
    if (cls_a_s[1] || cls_b_s[1]) begin
      spc_res_s = QNAN;
      spc_nv_s  = cls_a_s[0] || cls_b_s[0];
    end else if ((cls_a_s[2] && cls_b_s[3]) || (cls_a_s[3] && cls_b_s[2])) begin
      spc_res_s = QNAN;
      spc_nv_s  = 1'b1;
    end else if (cls_a_s[2] || cls_b_s[2]) begin
      spc_res_s = {sign_in_s, EXP_ONES, {MAN_W{1'b0}}};
    end else begin
      spc_res_s = {sign_in_s, {(W-1){1'b0}}};
    end
  end

  // Next-state logic for the IDLE -> MUL -> NORM -> DONE sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = special_s ? NORM : MUL;
        end else begin
          state_s = IDLE;
        end
      end
      MUL: begin
        if (cnt_r == CNT_LAST) begin
          state_s = NORM;
        end else begin
          state_s = MUL;
        end
      end
      NORM: state_s = DONE;
      DONE: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture and shift-add product accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= {CNT_W{1'b0}};
      sign_r    <= 1'b0;
      exp_r     <= EXP_ZERO;
      mcand_r   <= {P{1'b0}};
      mplier_r  <= {M{1'b0}};
      acc_r     <= {P{1'b0}};
      spec_r    <= 1'b0;
      spc_res_r <= {W{1'b0}};
      spc_nv_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cnt_r     <= {CNT_W{1'b0}};
            sign_r    <= sign_in_s;
            exp_r     <= {2'b00, bus.a[W-2:MAN_W]} + {2'b00, bus.b[W-2:MAN_W]} - BIAS;
            mcand_r   <= {{M{1'b0}}, 1'b1, bus.a[MAN_W-1:0]};
            mplier_r  <= {1'b1, bus.b[MAN_W-1:0]};
            acc_r     <= {P{1'b0}};
            spec_r    <= special_s;
            spc_res_r <= spc_res_s;
            spc_nv_r  <= spc_nv_s;
          end
        end
        MUL: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end
          mcand_r  <= {mcand_r[P-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[M-1:1]};
          cnt_r    <= cnt_r + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Normalise, round to nearest even, then range-check the rounded exponent.
  always_comb begin
    pn_s     = acc_r[P-1] ? acc_r : {acc_r[P-2:0], 1'b0};
    kept_s   = pn_s[P-1 -: M];
    guard_s  = pn_s[M-1];
    sticky_s = |pn_s[M-2:0];
    inc_s    = guard_s && (sticky_s || kept_s[0]);
    rnd_s    = {1'b0, kept_s} + {{M{1'b0}}, inc_s};
    e_fin_s  = exp_r + {{(XW-1){1'b0}}, acc_r[P-1]} + {{(XW-1){1'b0}}, rnd_s[M]};
    res_s    = {W{1'b0}};
    res_nv_s = 1'b0;
    res_of_s = 1'b0;
    res_uf_s = 1'b0;
    res_nx_s = 1'b0;
    if (spec_r) begin
      res_s    = spc_res_r;
      res_nv_s = spc_nv_r;
    end else if (e_fin_s >= EXP_MAX) begin
      res_s    = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
      res_of_s = 1'b1;
      res_nx_s = 1'b1;
    end else if (e_fin_s <= EXP_ZERO) begin
      res_s    = {sign_r, {(W-1){1'b0}}};
      res_uf_s = 1'b1;
      res_nx_s = 1'b1;
    end else begin
      res_s    = {sign_r, e_fin_s[EXP_W-1:0], rnd_s[MAN_W-1:0]};
      res_nx_s = guard_s || sticky_s;
    end
  end

  // Registered handshake outputs; result is loaded once, leaving NORM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      s_r         <= {W{1'b0}};
      nv_r        <= 1'b0;
      of_r        <= 1'b0;
      uf_r        <= 1'b0;
      nx_r        <= 1'b0;
    end else begin
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      if (state_r == NORM) begin
        s_r  <= res_s;
        nv_r <= res_nv_s;
        of_r <= res_of_s;
        uf_r <= res_uf_s;
        nx_r <= res_nx_s;
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.s         = s_r;
  assign bus.flag_nv   = nv_r;
  assign bus.flag_of   = of_r;
  assign bus.flag_uf   = uf_r;
  assign bus.flag_nx   = nx_r;
endmodule

// File: tb/tb_fmul_seq.sv
// Bench for fmul_seq: single- and half-precision instances against an arithmetic
// reference model, with per-cycle handshake, latency, result and flag checks.
module tb_fmul_seq;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;

  fmul_seq_if #(.W(32)) bus32 ();
  fmul_seq_if #(.W(16)) bus16 ();

  fmul_seq #(.EXP_W(8), .MAN_W(23)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  fmul_seq #(.EXP_W(5), .MAN_W(10)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact integer product, rounding decided from the discarded remainder.
  function automatic void fp_model(input int ew, input int mw, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] s,
                                   output logic [3:0] fl, output int lat);
    longint one, ones, fmask, fa, fb, ma, mb, prod, kept, rem, half, sg, res;
    int     ea, eb, e, sh, bias;
    bit     nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, snan;
    one    = 64'sd1;
    ones   = (one <<< ew) - one;
    fmask  = (one <<< mw) - one;
    bias   = int'((one <<< (ew - 1)) - one);
    ea     = int'((longint'(a) >>> mw) & ones);
    eb     = int'((longint'(b) >>> mw) & ones);
    fa     = longint'(a) & fmask;
    fb     = longint'(b) & fmask;
    sg     = ((longint'(a) >>> (ew + mw)) ^ (longint'(b) >>> (ew + mw))) & one;
    nan_a  = (ea == int'(ones)) && (fa != 0);
    nan_b  = (eb == int'(ones)) && (fb != 0);
    inf_a  = (ea == int'(ones)) && (fa == 0);
    inf_b  = (eb == int'(ones)) && (fb == 0);
    zero_a = (ea == 0);
    zero_b = (eb == 0);
    snan   = (nan_a && (((fa >>> (mw - 1)) & one) == 0)) ||
             (nan_b && (((fb >>> (mw - 1)) & one) == 0));
    fl     = 4'b0000;
    lat    = 1;
    if (nan_a || nan_b) begin
      res   = (ones <<< mw) | (one <<< (mw - 1));
      fl[3] = snan;
    end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
      res   = (ones <<< mw) | (one <<< (mw - 1));
      fl[3] = 1'b1;
    end else if (inf_a || inf_b) begin
      res = (sg <<< (ew + mw)) | (ones <<< mw);
    end else if (zero_a || zero_b) begin
      res = sg <<< (ew + mw);
    end else begin
      lat  = mw + 2;
      ma   = fa | (one <<< mw);
      mb   = fb | (one <<< mw);
      prod = ma * mb;
      e    = ea + eb - bias;
      sh   = mw;
      if (prod >= (one <<< (2 * mw + 1))) begin
        sh = mw + 1;
        e  = e + 1;
      end
      kept = prod >>> sh;
      rem  = prod & ((one <<< sh) - one);
      half = one <<< (sh - 1);
      if (rem > half || (rem == half && (kept & one) == one)) kept = kept + one;
      if (kept == (one <<< (mw + 1))) begin
        kept = kept >>> 1;
        e    = e + 1;
      end
      if (e >= int'(ones)) begin
        res = (sg <<< (ew + mw)) | (ones <<< mw);
        fl  = 4'b0101;
      end else if (e <= 0) begin
        res = sg <<< (ew + mw);
        fl  = 4'b0011;
      end else begin
        res   = (sg <<< (ew + mw)) | (longint'(e) <<< mw) | (kept & fmask);
        fl[0] = (rem != 0);
      end
    end
    s = 32'(res);
  endfunction

  bit          armed   [2] = '{1'b0, 1'b0};
  bit          fresh   [2] = '{1'b0, 1'b0};
  int          since   [2] = '{0, 0};
  logic [31:0] exp_s   [2];
  logic [3:0]  exp_f   [2];
  int          exp_lat [2] = '{0, 0};

  task automatic chan(input int ch, input int ew, input int mw, input logic rst,
                      input logic iv, input logic ir, input logic ov, input logic ordy,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                      input logic [3:0] fl);
    if (!rst) begin
      armed[ch] = 1'b0;
      fresh[ch] = 1'b1;
      chk($sformatf("ch%0d_reset_outputs", ch), {ir, ov, s, fl}, 64'd0);
    end else begin
      chk($sformatf("ch%0d_in_ready", ch), ir, !armed[ch] && !fresh[ch]);
      fresh[ch] = 1'b0;
      if (armed[ch]) begin
        since[ch]++;
        chk($sformatf("ch%0d_out_valid_timing", ch), ov, (since[ch] - 1) >= exp_lat[ch]);
        if (ov) begin
          chk($sformatf("ch%0d_result", ch), s, exp_s[ch]);
          chk($sformatf("ch%0d_flags", ch), fl, exp_f[ch]);
          if (ordy) armed[ch] = 1'b0;
        end
      end else begin
        chk($sformatf("ch%0d_no_spurious_valid", ch), ov, 1'b0);
      end
      if (iv && ir) begin
        fp_model(ew, mw, a, b, exp_s[ch], exp_f[ch], exp_lat[ch]);
        armed[ch] = 1'b1;
        since[ch] = 0;
      end
    end
  endtask

  // Single compare process: both channels checked on every falling edge.
  always @(negedge clk) begin
    chan(0, 8, 23, rst_n, bus32.in_valid, bus32.in_ready, bus32.out_valid, bus32.out_ready,
         bus32.a, bus32.b, bus32.s,
         {bus32.flag_nv, bus32.flag_of, bus32.flag_uf, bus32.flag_nx});
    chan(1, 5, 10, rst_n, bus16.in_valid, bus16.in_ready, bus16.out_valid, bus16.out_ready,
         {16'd0, bus16.a}, {16'd0, bus16.b}, {16'd0, bus16.s},
         {bus16.flag_nv, bus16.flag_of, bus16.flag_uf, bus16.flag_nx});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue32(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (bus32.in_ready !== 1'b1 && n < 200) begin step(); n++; end
    chk("issue32_wait_ready", bus32.in_ready, 1'b1);
    bus32.a        = a;
    bus32.b        = b;
    bus32.in_valid = 1'b1;
    step();
    bus32.in_valid = 1'b0;
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    while (bus16.in_ready !== 1'b1 && n < 200) begin step(); n++; end
    chk("issue16_wait_ready", bus16.in_ready, 1'b1);
    bus16.a        = a;
    bus16.b        = b;
    bus16.in_valid = 1'b1;
    step();
    bus16.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus32.in_ready !== 1'b1 || bus16.in_ready !== 1'b1) && n < 200) begin step(); n++; end
    chk("wait_idle", {bus32.in_ready, bus16.in_ready}, 2'b11);
  endtask

  logic [63:0] vec32 [14] = '{
    64'h3FC00000_40000000, 64'h40400000_40A00000, 64'h3F800001_3F800001,
    64'hBF800000_3F800000, 64'h7F800000_00000000, 64'hFF800000_40000000,
    64'h7FA00000_3F800000, 64'h7F000000_7F000000, 64'h00800000_00800000,
    64'h7FC00000_3F800000, 64'h00000000_C0000000, 64'h7F800000_FF800000,
    64'h3F800001_3FC00000, 64'h3FFFFFFF_3F800001
  };
  logic [31:0] vec16 [5] = '{
    32'h3E00_4000, 32'h7BFF_7BFF, 32'h3C01_3C01, 32'h7C00_0000, 32'h0400_0400
  };

  initial begin
    logic [31:0] ms;
    logic [3:0]  mf;
    int          ml;
    logic [31:0] ra, rb;
    logic [63:0] v;
    logic [31:0] h;
    rst_n           = 1'b0;
    bus32.in_valid  = 1'b0;
    bus32.a         = 32'd0;
    bus32.b         = 32'd0;
    bus32.out_ready = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.a         = 16'd0;
    bus16.b         = 16'd0;
    bus16.out_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;

    // Hand-computed expectations anchoring the reference model.
    fp_model(8, 23, 32'h3FC00000, 32'h40000000, ms, mf, ml);
    chk("model_1p5x2", {ms, mf, 28'(ml)}, {32'h40400000, 4'b0000, 28'd25});
    fp_model(8, 23, 32'h40400000, 32'h40A00000, ms, mf, ml);
    chk("model_3x5", {ms, mf}, {32'h41700000, 4'b0000});
    fp_model(8, 23, 32'h3F800001, 32'h3F800001, ms, mf, ml);
    chk("model_round", {ms, mf}, {32'h3F800002, 4'b0001});
    fp_model(8, 23, 32'h7F800000, 32'h00000000, ms, mf, ml);
    chk("model_inf_x_zero", {ms, mf, 28'(ml)}, {32'h7FC00000, 4'b1000, 28'd1});
    fp_model(8, 23, 32'h7F000000, 32'h7F000000, ms, mf, ml);
    chk("model_overflow", {ms, mf}, {32'h7F800000, 4'b0101});
    fp_model(8, 23, 32'h00800000, 32'h00800000, ms, mf, ml);
    chk("model_underflow", {ms, mf}, {32'h00000000, 4'b0011});
    fp_model(5, 10, 32'h3E00, 32'h4000, ms, mf, ml);
    chk("model_half_1p5x2", {ms, mf, 28'(ml)}, {32'h4200, 4'b0000, 28'd12});
    fp_model(5, 10, 32'h7BFF, 32'h7BFF, ms, mf, ml);
    chk("model_half_overflow", {ms, mf}, {32'h7C00, 4'b0101});

    foreach (vec32[i]) begin
      v = vec32[i];
      issue32(v[63:32], v[31:0]);
    end
    for (int i = 0; i < 6; i++) begin
      ra = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
      rb = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
      issue32(ra, rb);
    end
    wait_idle();

    // Backpressure: result and flags must hold while out_ready is low.
    bus32.out_ready = 1'b0;
    issue32(32'h40400000, 32'h40A00000);
    for (int n = 0; n < 100 && bus32.out_valid !== 1'b1; n++) step();
    chk("bp_out_valid_seen", bus32.out_valid, 1'b1);
    repeat (10) step();
    chk("bp_hold_s", bus32.s, 32'h41700000);
    chk("bp_in_ready_low", bus32.in_ready, 1'b0);
    bus32.out_ready = 1'b1;
    step();
    chk("bp_release_in_ready", bus32.in_ready, 1'b1);
    chk("bp_release_out_valid", bus32.out_valid, 1'b0);

    // Reset mid-multiply: outputs clear asynchronously and no result follows.
    issue32(32'h3FC00000, 32'h40000000);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("rst_async_clear", {bus32.in_ready, bus32.out_valid, bus32.s,
                            bus32.flag_nv, bus32.flag_of, bus32.flag_uf, bus32.flag_nx}, 64'd0);
    step();
    rst_n = 1'b1;
    repeat (40) step();
    issue32(32'h40400000, 32'h40A00000);
    wait_idle();

    foreach (vec16[i]) begin
      h = vec16[i];
      issue16(h[31:16], h[15:0]);
    end
    issue16(16'h3E00, 16'h4000);
    issue32(32'hC0000000, 32'h3FC00000);
    wait_idle();
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
